dmi_arbiter: RTL and testbench

//  Shares one Debug Module DMI port between N_REQ DMI masters (JTAG DTM, UART debug bridge, ...).

---
 rtl/dmi_pkg.sv | 34 +++
 rtl/dmi_arbiter_rr.sv | 30 +++
 rtl/dmi_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmi_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// Shared DMI types: operation codes, response codes and the arbiter FSM states,
// plus small helpers used by the DMI arbiter and its round-robin picker.
package dmi_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } dmi_op_e;

  // Encoding is shared with the DTM dmistat field, hence the gap at 1.
  typedef enum logic [1:0] {
    NOERROR = 2'd0,
    FAILED  = 2'd2,
    BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } dmi_arb_state_e;

  function automatic logic is_access(dmi_op_e op);
    return (op == READ) || (op == WRITE);
  endfunction

  function automatic int rr_index(int last, int k, int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/dmi_arbiter_rr.sv
// Combinational round-robin picker: first pending requester strictly after
// last_grant, wrapping around. Holds no state of its own.
module rr_arbiter
  import dmi_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last_grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'(rr_index(int'(last_grant), k, N));
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one Debug Module DMI port between N_REQ masters: latches requests,
// grants round-robin with one access in flight, and bounds each access by a timeout.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ABITS          = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_start,
  input  logic [N_REQ-1:0][1:0]       req_op,
  input  logic [N_REQ-1:0][ABITS-1:0] req_address,
  input  logic [N_REQ-1:0][31:0]      req_wdata,
  output logic [N_REQ-1:0]            req_finish,
  output logic [N_REQ-1:0][31:0]      req_rdata,
  output logic [N_REQ-1:0][1:0]       req_resp,
  output logic                        dm_start,
  output logic [1:0]                  dm_op,
  output logic [ABITS-1:0]            dm_address,
  output logic [31:0]                 dm_wdata,
  input  logic                        dm_finish,
  input  logic [31:0]                 dm_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  dmi_arb_state_e   state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] pending_set;
  logic [N_REQ-1:0] pending_clr;
  dmi_op_e          lat_op      [N_REQ];
  logic [ABITS-1:0] lat_address [N_REQ];
  logic [31:0]      lat_wdata   [N_REQ];
  logic [IW-1:0]    grant;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic [TW-1:0]    timer;
  logic             access_done;
  logic             access_timeout;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // A master stays busy from acceptance until the cycle its finish pulse is out.
  always_comb begin
    busy        = pending | req_finish;
    accept      = '0;
    pending_set = '0;
    pending_clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state != IDLE && grant == IW'(i)) busy[i] = 1'b1;
      accept[i]      = req_start[i] & ~busy[i];
      pending_set[i] = accept[i] & is_access(dmi_op_e'(req_op[i]));
      if (state == ISSUE && grant == IW'(i)) pending_clr[i] = 1'b1;
    end
  end

  assign access_done    = (state == ISSUE || state == WAIT) && dm_finish;
  assign access_timeout = (state == WAIT) && (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      last_grant <= IW'(N_REQ - 1);
      timer      <= '0;
      req_finish <= '0;
      req_rdata  <= '0;
      req_resp   <= '0;
      dm_start   <= 1'b0;
      dm_op      <= '0;
      dm_address <= '0;
      dm_wdata   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        lat_op[i]      <= NOP;
        lat_address[i] <= '0;
        lat_wdata[i]   <= '0;
      end
    end else begin
      req_finish <= '0;
      dm_start   <= 1'b0;
      pending    <= (pending & ~pending_clr) | pending_set;

      // nop/reserved ops never reach the DM and complete on the next cycle.
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          if (pending_set[i]) begin
            lat_op[i]      <= dmi_op_e'(req_op[i]);
            lat_address[i] <= req_address[i];
            lat_wdata[i]   <= req_wdata[i];
          end else begin
            req_finish[i] <= 1'b1;
            req_resp[i]   <= (dmi_op_e'(req_op[i]) == RSVD) ? FAILED : NOERROR;
          end
        end
      end

      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant      <= arb_idx;
            dm_start   <= 1'b1;
            dm_op      <= lat_op[arb_idx];
            dm_address <= lat_address[arb_idx];
            dm_wdata   <= lat_wdata[arb_idx];
            state      <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (access_done || access_timeout) begin
            req_finish[grant] <= 1'b1;
            req_rdata[grant]  <= (access_done && lat_op[grant] == READ) ? dm_rdata : 32'h0;
            req_resp[grant]   <= access_done ? NOERROR : FAILED;
            state             <= RESPOND;
          end else begin
            timer <= (state == ISSUE) ? '0 : timer + 1'b1;
            state <= WAIT;
          end
        end
        RESPOND: begin
          last_grant <= grant;
          dm_op      <= '0;
          dm_address <= '0;
          dm_wdata   <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios then random traffic,
// compared cycle by cycle against a transaction-timing model of the arbiter.
module tb_dmi_arbiter;

  localparam int N  = 3;
  localparam int AB = 7;
  localparam int TC = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_start;
  logic [N-1:0][1:0]      req_op;
  logic [N-1:0][AB-1:0]   req_address;
  logic [N-1:0][31:0]     req_wdata;
  logic [N-1:0]           req_finish;
  logic [N-1:0][31:0]     req_rdata;
  logic [N-1:0][1:0]      req_resp;
  logic                   dm_start;
  logic [1:0]             dm_op;
  logic [AB-1:0]          dm_address;
  logic [31:0]            dm_wdata;
  logic                   dm_finish;
  logic [31:0]            dm_rdata;

  dmi_arbiter #(
    .N_REQ          (N),
    .ABITS          (AB),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_start   (req_start),
    .req_op      (req_op),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_finish  (req_finish),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .dm_start    (dm_start),
    .dm_op       (dm_op),
    .dm_address  (dm_address),
    .dm_wdata    (dm_wdata),
    .dm_finish   (dm_finish),
    .dm_rdata    (dm_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: pending requests, the single access in flight and its timing.
  bit          m_pend  [N];
  int          m_op    [N];
  logic [AB-1:0] m_addr [N];
  logic [31:0] m_wdata [N];
  int          exp_fin [N];
  logic [31:0] exp_rdata [N];
  logic [31:0] new_rdata [N];
  logic [1:0]  exp_resp  [N];
  logic [1:0]  new_resp  [N];
  int          cur, last_g, issue_cyc, fin_cyc, cur_lat, idle_from;
  logic [31:0] cur_data;
  int          lat_q [$];
  logic [31:0] data_q [$];

  logic [N-1:0]  st_start;
  int            st_op   [N];
  logic [AB-1:0] st_addr [N];
  logic [31:0]   st_wdata[N];
  bit            rand_stale;

  task automatic checkValue(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] cycle %0d: observed %0h expected %0h", tag, idx, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_pend[i]    = 1'b0;
      exp_fin[i]   = -1;
      exp_rdata[i] = 32'h0;
      exp_resp[i]  = 2'd0;
    end
    cur       = -1;
    last_g    = N - 1;
    idle_from = 0;
  endtask

  task automatic checkResetState();
    for (int i = 0; i < N; i++) begin
      checkValue("rst_finish", i, 32'(req_finish[i]), 32'h0);
      checkValue("rst_rdata", i, req_rdata[i], 32'h0);
      checkValue("rst_resp", i, 32'(req_resp[i]), 32'h0);
    end
    checkValue("rst_dm_start", 0, 32'(dm_start), 32'h0);
    checkValue("rst_dm_op", 0, 32'(dm_op), 32'h0);
    checkValue("rst_dm_address", 0, 32'(dm_address), 32'h0);
    checkValue("rst_dm_wdata", 0, dm_wdata, 32'h0);
  endtask

  task automatic checkOutput();
    bit active;
    // Arbitration only when nothing is in flight; a grant here gives dm_start next cycle.
    if (cur < 0 && cyc >= idle_from) begin
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (last_g + k) % N;
        if (cur < 0 && m_pend[m]) begin
          cur       = m;
          m_pend[m] = 1'b0;
          issue_cyc = cyc + 1;
          if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
          else if ($urandom % 10 == 0) cur_lat = TC + 3;
          else cur_lat = $urandom_range(0, 4);
          if (data_q.size() > 0) cur_data = data_q.pop_front();
          else cur_data = $urandom;
          if (cur_lat <= TC) begin
            fin_cyc      = issue_cyc + cur_lat + 1;
            new_rdata[m] = (m_op[m] == 1) ? cur_data : 32'h0;
            new_resp[m]  = 2'd0;
          end else begin
            fin_cyc      = issue_cyc + TC + 1;
            new_rdata[m] = 32'h0;
            new_resp[m]  = 2'd2;
          end
          exp_fin[m] = fin_cyc;
          idle_from  = fin_cyc + 1;
          last_g     = m;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (exp_fin[i] == cyc) begin
        exp_rdata[i] = new_rdata[i];
        exp_resp[i]  = new_resp[i];
      end
      checkValue("req_finish", i, 32'(req_finish[i]), 32'(exp_fin[i] == cyc));
      checkValue("req_rdata", i, req_rdata[i], exp_rdata[i]);
      checkValue("req_resp", i, 32'(req_resp[i]), 32'(exp_resp[i]));
    end
    active = (cur >= 0) && (cyc >= issue_cyc) && (cyc <= fin_cyc);
    checkValue("dm_start", 0, 32'(dm_start), 32'((cur >= 0) && (cyc == issue_cyc)));
    checkValue("dm_op", 0, 32'(dm_op), active ? 32'(m_op[cur]) : 32'h0);
    if (active) begin
      checkValue("dm_address", 0, 32'(dm_address), 32'(m_addr[cur]));
      checkValue("dm_wdata", 0, dm_wdata, m_wdata[cur]);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    checkOutput();
    dm_finish = 1'b0;
    dm_rdata  = $urandom;
    if (cur >= 0 && cur_lat <= TC && cyc == issue_cyc + cur_lat) begin
      dm_finish = 1'b1;
      dm_rdata  = cur_data;
    end else if (cur >= 0 && cur_lat > TC && cyc == fin_cyc) begin
      dm_finish = 1'b1;
    end else if (rand_stale && (cur < 0 || cyc < issue_cyc || cyc == fin_cyc) && ($urandom % 6 == 0)) begin
      dm_finish = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      req_start[i]   = st_start[i];
      req_op[i]      = st_start[i] ? 2'(st_op[i]) : 2'($urandom);
      req_address[i] = st_start[i] ? st_addr[i] : AB'($urandom);
      req_wdata[i]   = st_start[i] ? st_wdata[i] : $urandom;
      if (st_start[i] && !(m_pend[i] || cur == i || exp_fin[i] >= cyc)) begin
        if (st_op[i] == 1 || st_op[i] == 2) begin
          m_pend[i]  = 1'b1;
          m_op[i]    = st_op[i];
          m_addr[i]  = st_addr[i];
          m_wdata[i] = st_wdata[i];
        end else begin
          exp_fin[i]   = cyc + 1;
          new_rdata[i] = exp_rdata[i];
          new_resp[i]  = (st_op[i] == 3) ? 2'd2 : 2'd0;
        end
      end
    end
    st_start = '0;
    if (cur >= 0 && cyc == fin_cyc) cur = -1;
  endtask

  task automatic setStart(input int i, input int op, input logic [AB-1:0] addr, input logic [31:0] wdata);
    st_start[i] = 1'b1;
    st_op[i]    = op;
    st_addr[i]  = addr;
    st_wdata[i] = wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic midReset();
    req_start = '0;
    dm_finish = 1'b0;
    rst       = 1'b1;
    #1;
    checkResetState();
    modelReset();
    @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    req_start   = '0;
    req_op      = '0;
    req_address = '0;
    req_wdata   = '0;
    dm_finish   = 1'b0;
    dm_rdata    = '0;
    st_start    = '0;
    rand_stale  = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single read");
    lat_q.push_back(3);
    data_q.push_back(32'hDEADBEEF);
    setStart(0, 1, 7'h10, 32'h0);
    applyStimulus();
    idle(8);

    $display("[TB] contention");
    lat_q.push_back(1);
    lat_q.push_back(2);
    setStart(0, 2, AB'($urandom), $urandom);
    setStart(1, 2, AB'($urandom), $urandom);
    applyStimulus();
    idle(14);
    setStart(0, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(10);
    setStart(0, 2, AB'($urandom), $urandom);
    setStart(1, 2, AB'($urandom), $urandom);
    applyStimulus();
    idle(14);

    $display("[TB] timeout");
    lat_q.push_back(TC + 4);
    setStart(1, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(TC + 8);

    $display("[TB] finish at terminal count");
    lat_q.push_back(TC);
    data_q.push_back(32'hCAFEF00D);
    setStart(0, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(TC + 6);

    $display("[TB] nop, reserved and busy starts");
    setStart(0, 0, AB'($urandom), $urandom);
    applyStimulus();
    setStart(0, 1, AB'($urandom), $urandom);
    applyStimulus();
    idle(3);
    setStart(0, 3, AB'($urandom), $urandom);
    applyStimulus();
    idle(3);
    lat_q.push_back(4);
    setStart(0, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(2);
    setStart(0, 2, AB'($urandom), $urandom);
    applyStimulus();
    idle(10);

    $display("[TB] reset during wait");
    lat_q.push_back(1000);
    setStart(1, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(5);
    midReset();
    lat_q.push_back(2);
    lat_q.push_back(2);
    setStart(0, 1, AB'($urandom), 32'h0);
    setStart(1, 1, AB'($urandom), 32'h0);
    applyStimulus();
    idle(14);

    $display("[TB] random traffic");
    rand_stale = 1'b1;
    repeat (2500) begin
      for (int i = 0; i < N; i++)
        if ($urandom % 4 == 0) setStart(i, int'($urandom_range(0, 3)), AB'($urandom), $urandom);
      applyStimulus();
    end
    rand_stale = 1'b0;
    idle(3 * N * (TC + 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
